alu_seq: RTL and testbench

- Parametrised, registered successor to the combinational datapath ALU.
- Adds comparison, shift, and iterative multiply/divide/remainder operations behind a start/busy/done handshake, so a multi-cycle CPU control FSM can stall on long operations.
- Sits in the execute stage. Operands and op are captured on start; the result is held until the next accepted start.

---
 rtl/alu_seq.sv | 163 ++++++++++++++++
 tb/tb_alu_seq.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered execute-stage ALU with iterative mul/divu/remu behind start/busy/done
module alu_seq #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] alu_out,
    output logic             alu_zero,
    output logic             alu_gtz
);

    localparam int SH_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIN
    } state_t;

    state_t state, state_nx;

    logic [3:0]       op_r;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic             is_multi;
    logic             last;
    logic [SH_W-1:0]  shamt;
    logic [WIDTH-1:0] sc_res;
    logic [WIDTH-1:0] it_ra;
    logic [WIDTH-1:0] it_rb;
    logic [WIDTH-1:0] it_acc;
    logic [WIDTH-1:0] fin_res;
    logic [WIDTH:0]   r_shift;
    logic             r_ge;
    logic [WIDTH-1:0] res_nx;
    logic             zero_nx;
    logic             gtz_nx;

    assign is_multi = (alu_op >= 4'd12) && (alu_op <= 4'd14);
    assign last     = (cnt == CNT_W'(1));
    assign busy     = (state == ITER);
    assign shamt    = alu_b[SH_W-1:0];

    // FIN accepts a new start exactly like IDLE, which is what makes back-to-back issue work.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            IDLE, FIN: begin
                state_nx = IDLE;
                if (start) begin
                    accept   = 1'b1;
                    state_nx = is_multi ? ITER : IDLE;
                end
            end
            ITER: begin
                if (last) begin
                    state_nx = FIN;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        sc_res = '0;
        case (alu_op)
            4'd1:    sc_res = alu_a + alu_b;
            4'd2:    sc_res = alu_a - alu_b;
            4'd3:    sc_res = alu_a & alu_b;
            4'd4:    sc_res = alu_a | alu_b;
            4'd5:    sc_res = alu_a ^ alu_b;
            4'd6:    sc_res = ~(alu_a | alu_b);
            4'd7:    sc_res = {{(WIDTH-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
            4'd8:    sc_res = {{(WIDTH-1){1'b0}}, (alu_a < alu_b)};
            4'd9:    sc_res = alu_a << shamt;
            4'd10:   sc_res = alu_a >> shamt;
            4'd11:   sc_res = $signed(alu_a) >>> shamt;
            default: sc_res = '0;
        endcase
    end

    // mul: ra = shifted multiplicand, rb = multiplier consumed LSB first, acc = partial product.
    // div: ra = dividend shifting out MSB first and collecting quotient bits, rb = divisor, acc = remainder.
    // A zero divisor always compares as fitting, giving all-ones quotient and remainder = dividend.
    always_comb begin
        it_ra   = ra;
        it_rb   = rb;
        it_acc  = acc;
        r_shift = {acc, ra[WIDTH-1]};
        r_ge    = (r_shift >= {1'b0, rb});
        fin_res = '0;
        if (op_r == 4'd12) begin
            it_acc  = rb[0] ? (acc + ra) : acc;
            it_ra   = ra << 1;
            it_rb   = rb >> 1;
            fin_res = it_acc;
        end else begin
            it_acc  = r_ge ? WIDTH'(r_shift - {1'b0, rb}) : r_shift[WIDTH-1:0];
            it_ra   = {ra[WIDTH-2:0], r_ge};
            fin_res = (op_r == 4'd13) ? it_ra : it_acc;
        end
    end

    assign res_nx  = accept ? sc_res : fin_res;
    assign zero_nx = (res_nx == '0);
    assign gtz_nx  = !res_nx[WIDTH-1] && (res_nx != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            done     <= 1'b0;
            alu_out  <= '0;
            alu_zero <= 1'b1;
            alu_gtz  <= 1'b0;
            cnt      <= '0;
            op_r     <= '0;
            ra       <= '0;
            rb       <= '0;
            acc      <= '0;
        end else begin
            state <= state_nx;
            done  <= 1'b0;
            if (accept) begin
                if (is_multi) begin
                    op_r <= alu_op;
                    ra   <= alu_a;
                    rb   <= alu_b;
                    acc  <= '0;
                    cnt  <= CNT_W'(WIDTH);
                end else begin
                    alu_out  <= res_nx;
                    alu_zero <= zero_nx;
                    alu_gtz  <= gtz_nx;
                    done     <= 1'b1;
                end
            end else if (state == ITER) begin
                ra  <= it_ra;
                rb  <= it_rb;
                acc <= it_acc;
                cnt <= cnt - CNT_W'(1);
                if (last) begin
                    alu_out  <= res_nx;
                    alu_zero <= zero_nx;
                    alu_gtz  <= gtz_nx;
                    done     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq at WIDTH=32 and WIDTH=8
module tb_alu_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        s32, s8;
    logic [3:0]  op32, op8;
    logic [31:0] a32, b32;
    logic [7:0]  a8, b8;
    logic        busy32, done32, zero32, gtz32;
    logic        busy8, done8, zero8, gtz8;
    logic [31:0] out32;
    logic [7:0]  out8;

    int checks = 0;
    int errors = 0;

    logic [33:0] q32[$];
    logic [9:0]  q8[$];

    alu_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(s32), .alu_op(op32), .alu_a(a32), .alu_b(b32),
        .busy(busy32), .done(done32), .alu_out(out32), .alu_zero(zero32), .alu_gtz(gtz32)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(s8), .alu_op(op8), .alu_a(a8), .alu_b(b8),
        .busy(busy8), .done(done8), .alu_out(out8), .alu_zero(zero8), .alu_gtz(gtz8)
    );

    function automatic logic [33:0] exp32(input logic [31:0] v);
        return {($signed(v) > 32'sd0), (v == 32'd0), v};
    endfunction

    function automatic logic [9:0] exp8(input logic [7:0] v);
        return {($signed(v) > 8'sd0), (v == 8'd0), v};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Result monitors: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done32) begin
            checks++;
            if (q32.size() == 0) begin
                errors++;
                $display("FAIL result32: unexpected done, out=%0h", out32);
            end else begin
                logic [33:0] e;
                e = q32.pop_front();
                if ({gtz32, zero32, out32} !== e) begin
                    errors++;
                    $display("FAIL result32: got gtz/zero/out %0h required %0h", {gtz32, zero32, out32}, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && done8) begin
            checks++;
            if (q8.size() == 0) begin
                errors++;
                $display("FAIL result8: unexpected done, out=%0h", out8);
            end else begin
                logic [9:0] e;
                e = q8.pop_front();
                if ({gtz8, zero8, out8} !== e) begin
                    errors++;
                    $display("FAIL result8: got gtz/zero/out %0h required %0h", {gtz8, zero8, out8}, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic push, input logic [31:0] val);
        s32 = 1'b1; op32 = op; a32 = a; b32 = b;
        if (push) q32.push_back(exp32(val));
        tick();
        s32 = 1'b0; op32 = 4'd0; a32 = '0; b32 = '0;
    endtask

    task automatic issue8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] val);
        s8 = 1'b1; op8 = op; a8 = a; b8 = b;
        q8.push_back(exp8(val));
        tick();
        s8 = 1'b0; op8 = 4'd0; a8 = '0; b8 = '0;
    endtask

    // Returns the cycle (1 = first cycle after accept) in which done is seen, and busy cycles before it.
    task automatic wait32(output int cyc, output int bcnt);
        cyc = 1; bcnt = 0;
        while (!done32 && cyc < 200) begin
            if (busy32) bcnt++;
            tick();
            cyc++;
        end
        if (!done32) chk("wait32_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait8(output int cyc, output int bcnt);
        cyc = 1; bcnt = 0;
        while (!done8 && cyc < 200) begin
            if (busy8) bcnt++;
            tick();
            cyc++;
        end
        if (!done8) chk("wait8_timeout", 64'd0, 64'd1);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
    } vec_t;

    vec_t sc_vecs[$];
    vec_t mc_vecs[$];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, bcnt, bsum;

        sc_vecs = '{
            '{4'd2,  32'd5,          32'd7,  32'hFFFF_FFFE},
            '{4'd7,  32'hFFFF_FFFF,  32'd1,  32'd1},
            '{4'd8,  32'hFFFF_FFFF,  32'd1,  32'd0},
            '{4'd11, 32'h8000_0000,  32'd31, 32'hFFFF_FFFF},
            '{4'd9,  32'd1,          32'd33, 32'd2},
            '{4'd6,  32'd0,          32'd0,  32'hFFFF_FFFF},
            '{4'd10, 32'h8000_0000,  32'd4,  32'h0800_0000},
            '{4'd1,  32'hFFFF_FFFF,  32'd1,  32'd0},
            '{4'd3,  32'h0000_F0F0,  32'h0000_FF00, 32'h0000_F000},
            '{4'd4,  32'h0000_00F0,  32'h0000_000F, 32'h0000_00FF},
            '{4'd5,  32'h0000_00FF,  32'h0000_000F, 32'h0000_00F0},
            '{4'd0,  32'd5,          32'd5,  32'd0},
            '{4'd15, 32'd5,          32'd5,  32'd0}
        };
        mc_vecs = '{
            '{4'd12, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000},
            '{4'd12, 32'h0001_0000,  32'h0001_0001, 32'h0001_0000},
            '{4'd12, 32'd1234,       32'd5678,      32'd7006652},
            '{4'd12, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1},
            '{4'd13, 32'd100,        32'd7,         32'd14},
            '{4'd14, 32'd100,        32'd7,         32'd2},
            '{4'd13, 32'd5,          32'd0,         32'hFFFF_FFFF},
            '{4'd14, 32'd5,          32'd0,         32'd5}
        };

        rst = 1'b1;
        s32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
        s8  = 1'b0; op8  = '0; a8  = '0; b8  = '0;
        tick();
        tick();
        chk("reset_flags32", {busy32, done32, zero32, gtz32}, 4'b0010);
        chk("reset_out32", out32, 32'd0);
        chk("reset_flags8", {busy8, done8, zero8, gtz8}, 4'b0010);
        rst = 1'b0;
        tick();

        // Reset in the middle of a multiply
        issue32(4'd1, 32'd10, 32'd20, 1'b1, 32'd30);
        wait32(cyc, bcnt);
        tick();
        issue32(4'd12, 32'd7, 32'd9, 1'b0, 32'd0);
        for (int i = 0; i < 9; i++) tick();
        chk("mid_mul_busy", busy32, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_mid_flags", {busy32, done32, zero32, gtz32}, 4'b0010);
        chk("rst_mid_out", out32, 32'd0);
        tick();
        rst = 1'b0;
        bsum = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy32 || done32) bsum++;
            tick();
        end
        chk("rst_no_resume", bsum, 0);
        issue32(4'd1, 32'd3, 32'd4, 1'b1, 32'd7);
        wait32(cyc, bcnt);
        chk("post_rst_add_latency", cyc, 1);
        tick();

        foreach (sc_vecs[i]) begin
            issue32(sc_vecs[i].op, sc_vecs[i].a, sc_vecs[i].b, 1'b1, sc_vecs[i].r);
            wait32(cyc, bcnt);
            chk($sformatf("sc_latency_op%0d", sc_vecs[i].op), cyc, 1);
            chk($sformatf("sc_busy_op%0d", sc_vecs[i].op), bcnt, 0);
            tick();
            tick();
            chk($sformatf("sc_hold_op%0d", sc_vecs[i].op), out32, sc_vecs[i].r);
        end

        foreach (mc_vecs[i]) begin
            issue32(mc_vecs[i].op, mc_vecs[i].a, mc_vecs[i].b, 1'b1, mc_vecs[i].r);
            wait32(cyc, bcnt);
            chk($sformatf("mc_latency_op%0d_%0d", mc_vecs[i].op, i), cyc, 33);
            chk($sformatf("mc_busy_op%0d_%0d", mc_vecs[i].op, i), bcnt, 32);
            tick();
        end

        // Back-to-back: start held high, add presented while divu iterates
        s32 = 1'b1; op32 = 4'd13; a32 = 32'd100; b32 = 32'd7;
        q32.push_back(exp32(32'd14));
        q32.push_back(exp32(32'd7));
        tick();
        op32 = 4'd1; a32 = 32'd3; b32 = 32'd4;
        wait32(cyc, bcnt);
        chk("b2b_div_latency", cyc, 33);
        chk("b2b_div_busy", bcnt, 32);
        tick();
        chk("b2b_add_done", {done32, busy32}, 2'b10);
        s32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
        tick();
        chk("b2b_done_ends", done32, 1'b0);
        chk("b2b_hold", out32, 32'd7);

        // WIDTH=8 instance
        issue8(4'd12, 8'd15, 8'd17, 8'hFF);
        wait8(cyc, bcnt);
        chk("w8_mul_latency", cyc, 9);
        chk("w8_mul_busy", bcnt, 8);
        tick();
        issue8(4'd13, 8'd255, 8'd16, 8'd15);
        wait8(cyc, bcnt);
        chk("w8_div_latency", cyc, 9);
        chk("w8_div_busy", bcnt, 8);
        tick();
        issue8(4'd14, 8'd255, 8'd16, 8'd15);
        wait8(cyc, bcnt);
        chk("w8_rem_latency", cyc, 9);
        tick();
        issue8(4'd1, 8'd200, 8'd100, 8'd44);
        wait8(cyc, bcnt);
        chk("w8_add_latency", cyc, 1);
        tick();
        tick();

        chk("q32_drained", q32.size(), 0);
        chk("q8_drained", q8.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
